round_ctrl: RTL
===============

# round_ctrl

Round sequencer for the reaction tug-of-war game. Owns the timing of every round and drives the scorer's control inputs (`winrnd`, `right`, `leds_on`, `tie`).
- Waits a pseudo-random delay, lights the LEDs, then decides who pressed first: right, left, tie, foul or timeout.
- Issues a one-cycle round result to the scorer.
- Halts when the scorer's score reaches either end.

## Interface
Parameters:
- `DELAY_MIN`, default 50_000_000: minimum cycles from round start to `leds_on`.
- `DELAY_RBITS`, default 26: random extra delay is the low `DELAY_RBITS` bits of the LFSR.
- `REACT_TIMEOUT`, default 100_000_000: cycles with `leds_on` high before the round is declared a tie.
- `COOLDOWN`, default 25_000_000: cycles after a result before the next round may start.
- `SEED`, default 16'hACE1: LFSR reset value, must be non-zero.

Ports:
- `clk`  in  1: system clock; single clock domain.
- `rst`  in  1: reset; synchronous, active-high.
- `pbl`  in  1: left player button, debounced level, synchronous to `clk`.
- `pbr`  in  1: right player button, debounced level, synchronous to `clk`.
- `score`  in  7: scorer position, one-hot; bit 0 = left end, bit 6 = right end.
- `leds_on`  out  1: round LEDs lit; high only in state REACT.
- `winrnd`  out  1: one-cycle round-result strobe.
- `right`  out  1: on `winrnd` cycle, 1 = right player won the round; otherwise 0.
- `tie`  out  1: on `winrnd` cycle, 1 = tied round (`right`=0); otherwise 0.
- `done`  out  1: game over, held until `rst`.

## Operation
- Press detection:
  - Registered `pbl_q`/`pbr_q`.
  - `el = pbl & ~pbl_q`, `er = pbr & ~pbr_q`.
  - Only rising edges count; held buttons never score.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every cycle in every state, including DONE. Resets to `SEED`.
- States: IDLE, WAIT, REACT, RESULT, COOL, DONE.
- IDLE:
  - if `score[0] | score[6]` -> DONE;
  - else if `pbl==0 && pbr==0` -> WAIT, loading `cnt = DELAY_MIN + lfsr[DELAY_RBITS-1:0]`.
- WAIT, early press is a foul; the other player wins:
  - `el & er` -> RESULT with tie=1;
  - `el` only -> RESULT with right=1;
  - `er` only -> RESULT with right=0.
  - Otherwise decrement `cnt`. At `cnt==0` -> REACT, loading `cnt = REACT_TIMEOUT-1`.
- REACT:
  - `el & er` -> tie;
  - `er` -> right=1;
  - `el` -> right=0;
  - `cnt==0` with no press -> tie.
  - Press takes priority over timeout in the same cycle.
- RESULT: `winrnd`=1 for exactly one cycle, with `right`/`tie` valid. Then -> COOL, loading `cnt = COOLDOWN-1`.
- COOL: decrement; at `cnt==0` -> IDLE. Presses are ignored.
- DONE: `done`=1. All other outputs 0. Only `rst` exits.
- Reset values:
  - state IDLE;
  - `leds_on`, `winrnd`, `right`, `tie`, `done` = 0;
  - `cnt`=0, `pbl_q`=`pbr_q`=0, LFSR=`SEED`.
- Reset mid-round: a round in progress is abandoned with no `winrnd` strobe. Reset dominates any press in the same cycle.
- Counter width: `$clog2(max(DELAY_MIN+2^DELAY_RBITS, REACT_TIMEOUT, COOLDOWN)+1)`. No wrap; loads never exceed this.

## Timing
- All outputs registered; no combinational input-to-output path.
- Press edge sampled at clock edge k: state RESULT and `winrnd`=1 during cycle k+1. `leds_on` drops at that same edge.
- WAIT -> REACT: `leds_on` rises at the edge after the delay counter reads 0. Delay from leaving IDLE to `leds_on` = loaded value + 1 cycles.
- `score` is sampled only in IDLE. This is at least `COOLDOWN` cycles after `winrnd`, so the scorer update has settled.
- Exactly one `winrnd` strobe per round. `right` and `tie` are never both 1.

## Structure
- `round_ctrl_defs.vh`: shared include holding the state encodings (3-bit localparams) and the LFSR tap mask, so the testbench can decode the state.
- Sub-module `lfsr16` (`clk`, `rst`, `SEED` param, 16-bit `q`), reusable by other game blocks.
- Edge detect and FSM stay in `round_ctrl`. Target 150–250 lines.

## Test plan
Bench parameters: `DELAY_MIN`=4, `DELAY_RBITS`=3, `REACT_TIMEOUT`=20, `COOLDOWN`=3, `SEED`=16'hACE1. Stub scorer, `score`=7'b0001000 unless stated.
1. Reset, buttons low -> outputs 0 during reset; `leds_on` rises 5..12 cycles after leaving IDLE. `pbr` pulse at edge k -> `winrnd`=1, `right`=1, `tie`=0 in cycle k+1 only; `leds_on`=0 from k+1.
2. `pbl` rises 2 cycles into WAIT -> foul: `winrnd`=1, `right`=1, `leds_on` never asserted that round.
3. `pbl` and `pbr` rise on the same edge in REACT -> `tie`=1, `right`=0. Repeat in WAIT with the same result.
4. No press in REACT -> `winrnd` with `tie`=1 exactly 20 cycles after `leds_on` rose. Hold `pbr` high through COOL -> stays in IDLE until release, and no result from the held button.
5. Set `score`=7'b1000000 during COOL -> `done`=1 on entering DONE, no further `leds_on`. Assert `rst` -> `done`=0 and a new round starts.
6. Assert `rst` for 1 cycle while `leds_on`=1 -> no `winrnd`, all outputs 0 next cycle, LFSR back to 16'hACE1.

Source files
------------

// File: rtl/round_ctrl_pkg.sv
// round_ctrl_pkg: shared definitions for the round sequencer.
// Holds the 3-bit FSM state encodings (so benches and other game blocks can
// decode the sequencer state), the LFSR tap mask, and a width helper.
package round_ctrl_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT   = 3'd1;
  localparam logic [2:0] ST_REACT  = 3'd2;
  localparam logic [2:0] ST_RESULT = 3'd3;
  localparam logic [2:0] ST_COOL   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // Galois form of x^16 + x^14 + x^13 + x^11 (right-shifting register).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/round_ctrl_lfsr16.sv
// lfsr16: free-running 16-bit Galois LFSR, reusable by other game blocks.
// Ports:
//   clk  in  1   system clock
//   rst  in  1   synchronous active-high reset, loads SEED
//   q    out 16  current LFSR state (advances every cycle)
module lfsr16
  import round_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,  // must be non-zero
  parameter logic [15:0] TAPS = LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_next;

  // Shift right; the bit falling out of q[0] is XORed into every tap position.
  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_bit
      assign q_next[gi] = q[gi+1] ^ (TAPS[gi] & q[0]);
    end
  endgenerate
  assign q_next[15] = TAPS[15] & q[0];

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= q_next;
  end

endmodule

// File: rtl/round_ctrl.sv
// round_ctrl: round sequencer for the reaction tug-of-war game.
// Waits a pseudo-random delay, lights the LEDs, decides who pressed first
// (right, left, tie, foul or timeout), strobes the result to the scorer for
// one cycle, cools down, and halts once the score reaches either end.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous active-high reset
//   pbl      in  1  left button, debounced level
//   pbr      in  1  right button, debounced level
//   score    in  7  one-hot scorer position (bit 0 left end, bit 6 right end)
//   leds_on  out 1  round LEDs lit (REACT only)
//   winrnd   out 1  one-cycle round-result strobe
//   right    out 1  with winrnd: right player won
//   tie      out 1  with winrnd: tied round
//   done     out 1  game over, held until rst
module round_ctrl
  import round_ctrl_pkg::*;
#(
  parameter int unsigned  DELAY_MIN     = 50_000_000,
  parameter int unsigned  DELAY_RBITS   = 26,
  parameter int unsigned  REACT_TIMEOUT = 100_000_000,
  parameter int unsigned  COOLDOWN      = 25_000_000,
  parameter logic [15:0]  SEED          = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  input  logic [6:0] score,
  output logic       leds_on,
  output logic       winrnd,
  output logic       right,
  output logic       tie,
  output logic       done
);

  localparam int unsigned CNT_MAX =
    max3(DELAY_MIN + (2 ** DELAY_RBITS), REACT_TIMEOUT, COOLDOWN);
  localparam int CW = $clog2(CNT_MAX + 1);

  logic [2:0]    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          pbl_q, pbr_q;
  logic          el, er;
  logic [15:0]   lfsr_q;
  logic          unused_bits;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only rising edges count, so a held button can never score.
  assign el = pbl & ~pbl_q;
  assign er = pbr & ~pbr_q;

  // Only the low LFSR bits and the end positions of score are consumed.
  assign unused_bits = ^{lfsr_q, score[5:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pbl_q     <= 1'b0;
      pbr_q     <= 1'b0;
      leds_on   <= 1'b0;
      winrnd    <= 1'b0;
      right     <= 1'b0;
      tie       <= 1'b0;
      done      <= 1'b0;
    end else begin
      pbl_q  <= pbl;
      pbr_q  <= pbr;
      // Result outputs are strobes; they are only set on the transition into RESULT.
      winrnd <= 1'b0;
      right  <= 1'b0;
      tie    <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (score[0] | score[6]) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end else if (!pbl && !pbr) begin
            // A button still held from the previous round blocks the start.
            state_reg <= ST_WAIT;
            cnt_reg   <= CW'(DELAY_MIN) + CW'(lfsr_q[DELAY_RBITS-1:0]);
          end
        end

        ST_WAIT: begin
          if (el | er) begin
            // Early press is a foul: the other player takes the round.
            state_reg <= ST_RESULT;
            winrnd    <= 1'b1;
            tie       <= el & er;
            right     <= el & ~er;
          end else if (cnt_reg == '0) begin
            state_reg <= ST_REACT;
            leds_on   <= 1'b1;
            cnt_reg   <= CW'(REACT_TIMEOUT - 1);
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end

        ST_REACT: begin
          // A press in the same cycle as the timeout still wins.
          if (el | er) begin
            state_reg <= ST_RESULT;
            leds_on   <= 1'b0;
            winrnd    <= 1'b1;
            tie       <= el & er;
            right     <= er & ~el;
          end else if (cnt_reg == '0) begin
            state_reg <= ST_RESULT;
            leds_on   <= 1'b0;
            winrnd    <= 1'b1;
            tie       <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end

        ST_RESULT: begin
          state_reg <= ST_COOL;
          cnt_reg   <= CW'(COOLDOWN - 1);
        end

        ST_COOL: begin
          if (cnt_reg == '0) state_reg <= ST_IDLE;
          else               cnt_reg   <= cnt_reg - CW'(1);
        end

        ST_DONE: begin
          done <= 1'b1;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
